// File: rtl/y_compactor_pkg.sv
// rtl/y_compactor_pkg.sv - shared types and constants for the response compactor
package y_compactor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] DEFAULT_SEED = 32'hFFFF_FFFF;

  // Number of SIG_WIDTH-wide slices needed to cover the zero-extended response bus.
  function automatic int slice_count(input int y_width, input int sig_width);
    return (y_width + sig_width - 1) / sig_width;
  endfunction

endpackage

// File: rtl/y_fold.sv
// rtl/y_fold.sv - combinational XOR fold of the response bus into one signature-wide word
module y_fold
  import y_compactor_pkg::*;
#(
  parameter int Y_WIDTH   = 385,
  parameter int SIG_WIDTH = 32
) (
  input  logic [Y_WIDTH-1:0]   i_y,
  output logic [SIG_WIDTH-1:0] o_fold
);

  localparam int N_SLICES = slice_count(Y_WIDTH, SIG_WIDTH);
  localparam int EXT_W    = N_SLICES * SIG_WIDTH;

  logic [EXT_W-1:0]     w_y_ext;
  logic [SIG_WIDTH-1:0] w_acc;

  assign w_y_ext = EXT_W'(i_y);

  always_comb begin
    w_acc = '0;
    for (int s = 0; s < N_SLICES; s++) begin
      w_acc = w_acc ^ w_y_ext[s*SIG_WIDTH +: SIG_WIDTH];
    end
  end

  assign o_fold = w_acc;

endmodule

// File: rtl/y_response_compactor.sv
// rtl/y_response_compactor.sv - MISR response compactor with run FSM and final signature compare
module y_response_compactor
  import y_compactor_pkg::*;
#(
  parameter int                   Y_WIDTH     = 385,
  parameter int                   SIG_WIDTH   = 32,
  parameter logic [SIG_WIDTH-1:0] POLY        = DEFAULT_POLY,
  parameter logic [SIG_WIDTH-1:0] SEED        = DEFAULT_SEED,
  parameter int                   NUM_VECTORS = 21
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 y_valid,
  input  logic [Y_WIDTH-1:0]   y,
  input  logic [SIG_WIDTH-1:0] exp_sig,
  input  logic                 done_ack,
  output logic                 busy,
  output logic [15:0]          vec_count,
  output logic [SIG_WIDTH-1:0] sig,
  output logic                 done,
  output logic                 pass
);

  localparam logic [15:0] LAST_COUNT = 16'(NUM_VECTORS - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SIG_WIDTH-1:0] r_sig;
  logic [15:0]          r_cnt;
  logic                 r_pass;
  logic                 r_busy;
  logic                 r_done;

  logic [SIG_WIDTH-1:0] w_fold;
  logic [SIG_WIDTH-1:0] w_next_sig;
  logic                 w_accept;
  logic                 w_last;

  y_fold #(
    .Y_WIDTH  (Y_WIDTH),
    .SIG_WIDTH(SIG_WIDTH)
  ) u_fold (
    .i_y   (y),
    .o_fold(w_fold)
  );

  assign w_next_sig = {r_sig[SIG_WIDTH-2:0], 1'b0}
                    ^ (r_sig[SIG_WIDTH-1] ? POLY : '0)
                    ^ w_fold;
  assign w_accept   = (r_state == ST_RUN) && y_valid;
  assign w_last     = (r_cnt == LAST_COUNT);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_accept && w_last) w_state_nxt = ST_DONE;
      ST_DONE: if (done_ack) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // busy/done are registered from the next state so every output comes straight off a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig  <= '0;
      r_cnt  <= '0;
      r_pass <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_RUN);
      r_done <= (w_state_nxt == ST_DONE);
      if (r_state == ST_IDLE && start) begin
        r_sig  <= SEED;
        r_cnt  <= '0;
        r_pass <= 1'b0;
      end else if (w_accept) begin
        r_sig <= w_next_sig;
        r_cnt <= r_cnt + 16'd1;
        if (w_last) begin
          r_pass <= (w_next_sig == exp_sig);
        end
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign sig       = r_sig;
  assign vec_count = r_cnt;

endmodule

// File: tb/tb_y_response_compactor.sv
// tb/tb_y_response_compactor.sv - directed self-checking bench for the response compactor
module tb_y_response_compactor;

  logic         clk;
  logic         rst_n;
  logic         y_valid;
  logic [384:0] y;
  logic [31:0]  exp_sig;
  logic         done_ack;
  logic         start_z, start_s, start_f, start_d;

  logic        busy_z, done_z, pass_z;
  logic [15:0] cnt_z;
  logic [31:0] sig_z;
  logic        busy_s, done_s, pass_s;
  logic [15:0] cnt_s;
  logic [31:0] sig_s;
  logic        busy_f, done_f, pass_f;
  logic [15:0] cnt_f;
  logic [31:0] sig_f;
  logic        busy_d, done_d, pass_d;
  logic [15:0] cnt_d;
  logic [31:0] sig_d;

  int          n_cmp;
  int          n_err;
  logic [31:0] ref_def;

  y_response_compactor #(.SEED(32'h0), .NUM_VECTORS(3)) u_zero (
    .clk(clk), .rst_n(rst_n), .start(start_z), .y_valid(y_valid), .y(y),
    .exp_sig(exp_sig), .done_ack(done_ack), .busy(busy_z), .vec_count(cnt_z),
    .sig(sig_z), .done(done_z), .pass(pass_z));

  y_response_compactor #(.SEED(32'h0), .NUM_VECTORS(2)) u_shift (
    .clk(clk), .rst_n(rst_n), .start(start_s), .y_valid(y_valid), .y(y),
    .exp_sig(exp_sig), .done_ack(done_ack), .busy(busy_s), .vec_count(cnt_s),
    .sig(sig_s), .done(done_s), .pass(pass_s));

  y_response_compactor #(.SEED(32'h8000_0000), .NUM_VECTORS(1)) u_fb (
    .clk(clk), .rst_n(rst_n), .start(start_f), .y_valid(y_valid), .y(y),
    .exp_sig(exp_sig), .done_ack(done_ack), .busy(busy_f), .vec_count(cnt_f),
    .sig(sig_f), .done(done_f), .pass(pass_f));

  y_response_compactor u_def (
    .clk(clk), .rst_n(rst_n), .start(start_d), .y_valid(y_valid), .y(y),
    .exp_sig(exp_sig), .done_ack(done_ack), .busy(busy_d), .vec_count(cnt_d),
    .sig(sig_d), .done(done_d), .pass(pass_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [384:0] gen_y(input int k);
    logic [384:0] v;
    v = '0;
    v[31:0]    = 32'(k) * 32'h9E37_79B9;
    v[127:96]  = ~32'(k);
    v[200 +: 32] = 32'hC0DE_0000 | 32'(k);
    v[384]     = k[0];
    return v;
  endfunction

  // Bitwise reference: bit i of the bus lands on signature bit i mod 32.
  function automatic logic [31:0] model_sig(input logic [31:0] seed, input int n);
    logic [31:0]  s;
    logic [31:0]  f;
    logic [384:0] v;
    s = seed;
    for (int k = 0; k < n; k++) begin
      v = gen_y(k);
      f = '0;
      for (int i = 0; i < 385; i++) f[i % 32] = f[i % 32] ^ v[i];
      if (s[31]) s = (s << 1) ^ 32'h04C1_1DB7;
      else       s = s << 1;
      s = s ^ f;
    end
    return s;
  endfunction

  task automatic ack_all();
    y_valid  = 1'b0;
    done_ack = 1'b1;
    tick();
    done_ack = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (sig_d !== 32'h0)  begin n_err++; $display("FAIL reset_sig: got %h want 0", sig_d); end
    n_cmp++; if (cnt_d !== 16'h0)  begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cnt_d); end
    n_cmp++; if ({busy_d, done_d, pass_d} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {busy_d, done_d, pass_d}); end
    n_cmp++; if ({busy_z, done_z, pass_z, busy_f, done_f} !== 5'b0) begin n_err++; $display("FAIL reset_others: got %b want 00000", {busy_z, done_z, pass_z, busy_f, done_f}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_zero();
    int edges;
    exp_sig = 32'h0;
    y       = '0;
    start_z = 1'b1;
    tick();
    edges   = 1;
    start_z = 1'b0;
    n_cmp++; if (busy_z !== 1'b1) begin n_err++; $display("FAIL zero_busy: got %b want 1", busy_z); end
    y_valid = 1'b1;
    while (!done_z && edges < 10) begin
      tick();
      edges++;
    end
    n_cmp++; if (edges !== 4)      begin n_err++; $display("FAIL zero_latency: got %0d want 4", edges); end
    n_cmp++; if (sig_z !== 32'h0)  begin n_err++; $display("FAIL zero_sig: got %h want 0", sig_z); end
    n_cmp++; if (pass_z !== 1'b1)  begin n_err++; $display("FAIL zero_pass: got %b want 1", pass_z); end
    n_cmp++; if (cnt_z !== 16'd3)  begin n_err++; $display("FAIL zero_cnt: got %0d want 3", cnt_z); end
    ack_all();
  endtask

  task automatic shift_run(input logic [31:0] e, input logic want_pass);
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    y       = '0;
    y[0]    = 1'b1;
    y_valid = 1'b1;
    tick();
    n_cmp++; if (sig_s !== 32'h1) begin n_err++; $display("FAIL shift_sig1: got %h want 1", sig_s); end
    y       = '0;
    exp_sig = e;
    tick();
    n_cmp++; if (sig_s !== 32'h2) begin n_err++; $display("FAIL shift_sig2: got %h want 2", sig_s); end
    n_cmp++; if (done_s !== 1'b1) begin n_err++; $display("FAIL shift_done: got %b want 1", done_s); end
    n_cmp++; if (pass_s !== want_pass) begin n_err++; $display("FAIL shift_pass_%h: got %b want %b", e, pass_s, want_pass); end
    ack_all();
  endtask

  task automatic test_shift();
    shift_run(32'h2, 1'b1);
    shift_run(32'h3, 1'b0);
  endtask

  task automatic test_feedback();
    start_f = 1'b1;
    tick();
    start_f = 1'b0;
    y       = '0;
    y[0]    = 1'b1;
    y[32]   = 1'b1;
    y[384]  = 1'b1;
    y_valid = 1'b1;
    exp_sig = 32'h04C1_1DB6;
    tick();
    n_cmp++; if (sig_f !== 32'h04C1_1DB6) begin n_err++; $display("FAIL fb_sig: got %h want 04c11db6", sig_f); end
    n_cmp++; if ({done_f, pass_f} !== 2'b11) begin n_err++; $display("FAIL fb_done_pass: got %b want 11", {done_f, pass_f}); end
    n_cmp++; if (cnt_f !== 16'd1) begin n_err++; $display("FAIL fb_cnt: got %0d want 1", cnt_f); end
    ack_all();
  endtask

  task automatic run_default(input logic stall, input logic pulse_start);
    int k;
    int cycles;
    logic [415:0] junk;
    exp_sig = ref_def;
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    n_cmp++; if (busy_d !== 1'b1) begin n_err++; $display("FAIL def_busy: got %b want 1", busy_d); end
    k = 0;
    cycles = 0;
    while (!done_d && cycles < 200) begin
      start_d = pulse_start && (cycles == 7);
      if (stall && cycles[0]) begin
        junk    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        y       = junk[384:0];
        y_valid = 1'b0;
      end else begin
        y       = gen_y(k);
        y_valid = 1'b1;
      end
      tick();
      if (y_valid) k++;
      cycles++;
      if (cycles == 20) begin
        n_cmp++; if (cnt_d !== 16'(stall ? 10 : 20)) begin n_err++; $display("FAIL def_midcount: got %0d want %0d", cnt_d, stall ? 10 : 20); end
      end
    end
    start_d = 1'b0;
    y_valid = 1'b0;
    n_cmp++; if (cycles !== (stall ? 41 : 21)) begin n_err++; $display("FAIL def_cycles: got %0d want %0d", cycles, stall ? 41 : 21); end
    n_cmp++; if (cnt_d !== 16'd21)   begin n_err++; $display("FAIL def_cnt: got %0d want 21", cnt_d); end
    n_cmp++; if (sig_d !== ref_def)  begin n_err++; $display("FAIL def_sig: got %h want %h", sig_d, ref_def); end
    n_cmp++; if (pass_d !== 1'b1)    begin n_err++; $display("FAIL def_pass: got %b want 1", pass_d); end
  endtask

  task automatic test_stalls();
    run_default(1'b0, 1'b0);
    ack_all();
    run_default(1'b1, 1'b1);
    ack_all();
  endtask

  task automatic test_reset_midrun();
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    for (int k = 0; k < 5; k++) begin
      y       = gen_y(k);
      y_valid = 1'b1;
      tick();
    end
    y_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (sig_d !== 32'h0)  begin n_err++; $display("FAIL rst_mid_sig: got %h want 0", sig_d); end
    n_cmp++; if (cnt_d !== 16'h0)  begin n_err++; $display("FAIL rst_mid_cnt: got %0d want 0", cnt_d); end
    n_cmp++; if ({busy_d, done_d, pass_d} !== 3'b000) begin n_err++; $display("FAIL rst_mid_flags: got %b want 000", {busy_d, done_d, pass_d}); end
    tick();
    rst_n = 1'b1;
    tick();
    run_default(1'b0, 1'b0);
  endtask

  task automatic test_handshake();
    done_ack = 1'b0;
    y_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      y = gen_y(i + 3);
      tick();
    end
    n_cmp++; if (sig_d !== ref_def) begin n_err++; $display("FAIL hs_sig_frozen: got %h want %h", sig_d, ref_def); end
    n_cmp++; if ({done_d, pass_d} !== 2'b11) begin n_err++; $display("FAIL hs_done_pass: got %b want 11", {done_d, pass_d}); end
    n_cmp++; if (cnt_d !== 16'd21) begin n_err++; $display("FAIL hs_cnt_frozen: got %0d want 21", cnt_d); end
    done_ack = 1'b1;
    start_d  = 1'b1;
    tick();
    done_ack = 1'b0;
    start_d  = 1'b0;
    n_cmp++; if ({busy_d, done_d} !== 2'b00) begin n_err++; $display("FAIL hs_ack_idle: got %b want 00", {busy_d, done_d}); end
    tick();
    n_cmp++; if (busy_d !== 1'b0) begin n_err++; $display("FAIL hs_no_restart: got %b want 0", busy_d); end
    n_cmp++; if (cnt_d !== 16'd21) begin n_err++; $display("FAIL hs_idle_ignores_valid: got %0d want 21", cnt_d); end
    y_valid = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    y_valid  = 1'b0;
    y        = '0;
    exp_sig  = '0;
    done_ack = 1'b0;
    start_z  = 1'b0;
    start_s  = 1'b0;
    start_f  = 1'b0;
    start_d  = 1'b0;
    ref_def  = model_sig(32'hFFFF_FFFF, 21);
    test_reset();
    test_zero();
    test_shift();
    test_feedback();
    test_stalls();
    test_reset_midrun();
    test_handshake();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/y_response_compactor.md
# y_response_compactor

Downstream response compactor for the fuzz-simulation flow. It sits directly after the synthesized `top` netlist and consumes its wide `y` output bus every clock. Each valid response is compressed into a 32-bit MISR signature. After a programmed number of vectors it compares the signature against an expected value and raises a pass/fail result. This replaces bit-by-bit `$strobe` comparison of simulator logs with a single signature check per run.

## Interface
- `Y_WIDTH`, 385, width of the response bus consumed from `top`.
- `SIG_WIDTH`, 32, signature width.
- `POLY`, 32'h04C1_1DB7, MISR feedback polynomial; bit i set means a tap at bit i.
- `SEED`, 32'hFFFF_FFFF, signature value loaded on `start`.
- `NUM_VECTORS`, 21, number of valid responses per run (range 1..65535).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `y_valid`  in  1  `y` holds a response to compact this cycle.
- `y`  in  `Y_WIDTH`  response bus from `top`.
- `exp_sig`  in  `SIG_WIDTH`  expected final signature; sampled on the cycle the run ends.
- `done_ack`  in  1  acknowledges the result; DONE returns to IDLE.
- `busy`  out  1  high in RUN.
- `vec_count`  out  16  valid responses compacted in the current run.
- `sig`  out  `SIG_WIDTH`  current signature register.
- `done`  out  1  high in DONE.
- `pass`  out  1  registered result `sig == exp_sig`; meaningful only while `done`.

## Operation
- FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE:**
  - When `start=1`, load `sig<=SEED` and `vec_count<=0`, then go to RUN.
  - `y_valid` is ignored in IDLE.
- **RUN:**
  - Each cycle with `y_valid=1`: `sig <= {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold(y)`, and `vec_count` increments.
  - When `y_valid=0`, hold both registers.
- **Fold function:**
  - Zero-extend `y` to `ceil(Y_WIDTH/32)*32` bits (416 for the default width).
  - XOR all 32-bit slices together. Slice 0 is `y[31:0]`.
- **RUN exit:** on the accepting cycle where `vec_count == NUM_VECTORS-1`:
  - The update is applied.
  - `pass <= (next_sig == exp_sig)`.
  - The FSM goes to DONE.
- **DONE:**
  - `sig`, `vec_count` and `pass` are frozen, and `y_valid` is ignored.
  - When `done_ack=1`, go to IDLE. Outputs keep their values until the next `start`.
- **Boundary conditions:**
  - `start` in RUN or DONE is ignored.
  - `start` and `done_ack` high together in DONE: only the ack takes effect. A new run needs a fresh `start` in IDLE.
  - `NUM_VECTORS=1`: the first valid response ends the run.

## Timing
- Reset values, applied asynchronously when `rst_n=0`:
  - state IDLE
  - `sig = 0`
  - `vec_count = 0`
  - `busy = 0`
  - `done = 0`
  - `pass = 0`
- `busy` rises one cycle after `start` is sampled.
- A response is accepted on the same edge it is presented. It is visible in `sig` one cycle later.
- `done`/`pass` are valid one cycle after the final accepted response, i.e. 1-cycle latency.
- A run with continuous `y_valid` takes `NUM_VECTORS + 1` cycles from the `start` edge to `done`.
- Asserting `rst_n` mid-run aborts the run immediately; no partial result is kept.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Package `y_compactor_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_RUN`, `ST_DONE`)
  - the default `POLY`/`SEED` constants
  - a localparam function computing the slice count from `Y_WIDTH`
- One sub-module, `y_fold`: purely combinational, parameterized by `Y_WIDTH` and `SIG_WIDTH`, XOR-reduces the slices.
- The top block holds the FSM, MISR register, counter and compare.

## Test plan
- **Zero response:** `SEED=0`, `NUM_VECTORS=3`, `y=0` with `y_valid=1` for 3 cycles -> `sig=0`, `pass=1` with `exp_sig=0`, `done` rises 4 cycles after the `start` edge.
- **Shift behaviour:** `SEED=0`, `NUM_VECTORS=2`:
  - `y=1`, then `y=0` -> `sig=32'h1` after the first response, `32'h2` after the second.
  - `exp_sig=2` -> `pass=1`; `exp_sig=3` -> `pass=0`.
- **Feedback and fold cancellation:** `SEED=32'h8000_0000`, `NUM_VECTORS=1`, `y` with bits 0, 32 and 384 set -> fold is `32'h1`, `sig = 32'h04C1_1DB6`.
- **Stalls:**
  - Default parameters with `y_valid` toggling 1,0,1,0… -> `vec_count` reaches 21 only after 21 valid cycles.
  - `sig` is identical to a run with continuous `y_valid`.
  - `start` pulsed during RUN has no effect.
- **Reset mid-run:** pull `rst_n` low after 5 vectors -> all outputs reach their reset values immediately, without waiting for a clock edge. A subsequent `start` run reproduces the reference signature.
- **Handshake:**
  - In DONE, hold `done_ack=0` for 10 cycles while driving `y_valid=1` -> `sig` and `pass` stay frozen.
  - Assert `done_ack` together with `start` -> returns to IDLE, `busy` stays 0.
